// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer: reset PC, memory depth,
// FSM encoding and the buffered {pc, inst} entry.
package fetch_pkg;

  localparam logic [31:0] DefResetPc = 32'h0000_3000;
  localparam int unsigned DefImWords = 2048;

  typedef enum logic {
    StRun,
    StFault
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // Word-aligned and inside [base, base + span); 32-bit unsigned compare, so a
  // wrapped PC+4 lands below base and is rejected.
  function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] base,
                                    input logic [31:0] span);
    logic [31:0] limit;
    limit = base + span;
    return (pc[1:0] == 2'b00) && (pc >= base) && (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory, redirect, decode handshake and fault signals of the
// fetch sequencer.
interface fetch_sequencer_if;
  logic [31:0] im_addr;
  logic [31:0] im_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output im_addr,
    input  im_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output fault,
    output fault_pc
  );

  modport slave (
    input  im_addr,
    output im_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  fault,
    input  fault_pc
  );
endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry in-order buffer of fetched {pc, inst} pairs with flush; the head
// always sits in slot 0.
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     wdata,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     e0_q, e0_d, e1_q, e1_d;
  logic [1:0] count_q, count_d;
  logic [1:0] wr_idx;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    // Slot the new entry lands in once any pop has shifted slot 1 down.
    wr_idx  = count_q - {1'b0, pop};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) e0_d = e1_q;
      if (push) begin
        if (wr_idx == 2'd0) e0_d = wdata;
        else                e1_d = wdata;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= 2'd0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  assign head  = e0_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Sequential instruction fetch with redirect, 2-deep output buffer and a
// sticky fault on PCs outside the legal fetch window.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefResetPc,
  parameter int unsigned IM_WORDS = DefImWords
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  localparam logic [31:0] FetchSpan = 32'(4 * IM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        push, pop, flush, legal;
  logic [1:0]  fifo_count;
  entry_t      head, wdata;

  assign legal         = pc_legal(pc_q, RESET_PC, FetchSpan);
  assign bus.out_valid = (fifo_count != 2'd0);
  assign pop           = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign wdata         = '{pc: pc_q, inst: bus.im_inst};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (bus.redirect_valid) begin
      flush      = 1'b1;
      pc_d       = bus.redirect_pc;
      state_d    = StRun;
      fault_pc_d = 32'd0;
    end else if (state_q == StRun) begin
      if (!legal) begin
        fault_pc_d = pc_q;
        state_d    = StFault;
      end else if (fifo_count != 2'd2 || pop) begin
        push = 1'b1;
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .head  (head),
    .count (fifo_count)
  );

  assign bus.im_addr  = pc_q;
  assign bus.out_inst = head.inst;
  assign bus.out_pc   = head.pc;
  assign bus.fault    = (state_q == StFault);
  assign bus.fault_pc = fault_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected {pc, inst} pairs are queued as
// each fetch stream is started and retired on every decode handshake.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  entry_t      exp_q[$];
  logic [31:0] last_acc_pc = 32'd0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC (32'h0000_3000),
    .IM_WORDS (2048)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign bus.im_inst = rom_word(bus.im_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = start + 32'(4 * i);
      e.inst = rom_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick(1);
    bus.redirect_valid = 1'b0;
  endtask

  // Retire one expected entry per accepted handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      last_acc_pc <= bus.out_pc;
      if (exp_q.size() > 0) begin
        entry_t e;
        e = exp_q.pop_front();
        check("sb_pc", bus.out_pc, e.pc);
        check("sb_inst", bus.out_inst, e.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3040;
    tick(2);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_fault_pc", bus.fault_pc, 32'd0);
    check("rst_im_addr", bus.im_addr, 32'h0000_3000);
    bus.redirect_valid = 1'b0;

    // Streaming from reset release
    bus.out_ready = 1'b1;
    expect_seq(32'h0000_3000, 3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("a_valid", 32'(bus.out_valid), 32'd1);
    end
    wait_drain("a_drain");

    // Backpressure after reset, then release
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(5);
    check("b_count", 32'(dut.fifo_count), 32'd2);
    check("b_im_addr", bus.im_addr, 32'h0000_3008);
    check("b_head_pc", bus.out_pc, 32'h0000_3000);
    expect_seq(32'h0000_3000, 4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b_valid", 32'(bus.out_valid), 32'd1);
      tick(1);
    end
    wait_drain("b_drain");

    // Redirect with two buffered entries
    bus.out_ready = 1'b0;
    tick(3);
    check("c_full", 32'(dut.fifo_count), 32'd2);
    exp_q.delete();
    bus.out_ready = 1'b1;
    redirect(32'h0000_3040);
    check("c_flush_valid", 32'(bus.out_valid), 32'd0);
    check("c_im_addr", bus.im_addr, 32'h0000_3040);
    expect_seq(32'h0000_3040, 2);
    tick(1);
    check("c_valid", 32'(bus.out_valid), 32'd1);
    check("c_pc", bus.out_pc, 32'h0000_3040);
    wait_drain("c_drain");

    // Misaligned redirect faults, aligned redirect recovers
    exp_q.delete();
    redirect(32'h0000_3002);
    check("d_flush", 32'(bus.out_valid), 32'd0);
    tick(1);
    check("d_fault", 32'(bus.fault), 32'd1);
    check("d_fault_pc", bus.fault_pc, 32'h0000_3002);
    check("d_no_push", 32'(bus.out_valid), 32'd0);
    tick(3);
    check("d_hold_addr", bus.im_addr, 32'h0000_3002);
    check("d_hold_fpc", bus.fault_pc, 32'h0000_3002);
    expect_seq(32'h0000_3000, 2);
    redirect(32'h0000_3000);
    check("d_clear", 32'(bus.fault), 32'd0);
    check("d_clear_fpc", bus.fault_pc, 32'd0);
    wait_drain("d_drain");

    // Running off the top of the window
    exp_q.delete();
    expect_seq(32'h0000_4FF0, 4);
    redirect(32'h0000_4FF0);
    for (int i = 0; i < 40; i++) begin
      if (bus.fault) break;
      tick(1);
    end
    check("e_fault", 32'(bus.fault), 32'd1);
    check("e_fault_pc", bus.fault_pc, 32'h0000_5000);
    wait_drain("e_drain");
    tick(2);
    check("e_empty", 32'(bus.out_valid), 32'd0);
    check("e_last_pc", last_acc_pc, 32'h0000_4FFC);

    // Reset beats a simultaneous redirect with a full buffer
    exp_q.delete();
    bus.out_ready = 1'b0;
    redirect(32'h0000_3000);
    tick(3);
    check("f_full", 32'(dut.fifo_count), 32'd2);
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3040;
    bus.out_ready      = 1'b1;
    tick(1);
    check("f_valid", 32'(bus.out_valid), 32'd0);
    check("f_im_addr", bus.im_addr, 32'h0000_3000);
    check("f_fault", 32'(bus.fault), 32'd0);
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the PC loaded on reset and the base of the legal fetch window.
REQ-002 SHALL have parameter IM_WORDS, default 2048, meaning the instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1, meaning the single clock (all state on rising edge).
REQ-004 SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-005 SHALL have port im_addr, output, 32, meaning the byte address to instruction memory (= current PC, combinational from the PC register).
REQ-006 SHALL have port im_inst, input, 32, meaning the instruction word, valid in the same cycle as im_addr (asynchronous-read memory).
REQ-007 SHALL have port redirect_valid, input, 1, meaning a branch/jump/exception redirect request.
REQ-008 SHALL have port redirect_pc, input, 32, meaning the redirect target byte address.
REQ-009 SHALL have port out_valid, output, 1, meaning out_inst/out_pc hold a fetched instruction.
REQ-010 SHALL have port out_ready, input, 1, meaning decode accepts this cycle.
REQ-011 SHALL have port out_inst, output, 32, meaning the oldest buffered instruction.
REQ-012 SHALL have port out_pc, output, 32, meaning the PC of out_inst.
REQ-013 SHALL have port fault, output, 1, meaning fetch has halted on an illegal PC.
REQ-014 SHALL have port fault_pc, output, 32, meaning the offending PC, held while fault=1.

Function
REQ-015 SHALL implement states RUN and FAULT; fault = (state==FAULT).
REQ-016 SHALL buffer fetched {pc, inst} pairs in a 2-entry FIFO; out_valid = (count != 0); out_* show the head entry.
REQ-017 SHALL define pop = out_valid && out_ready && !redirect_valid.
REQ-018 SHALL define legal = (PC[1:0]==0) && (PC >= RESET_PC) && (PC < RESET_PC + 4*IM_WORDS), with 32-bit unsigned compare.
REQ-019 SHALL, in RUN with no redirect, push {PC, im_inst} and set PC <= PC+4 when legal && (count<2 || pop).
REQ-020 SHALL, in RUN with no redirect and !legal, push nothing, hold PC, latch fault_pc <= PC and enter FAULT; entries already buffered remain drainable.
REQ-021 SHALL, when the FIFO is full and no pop occurs, hold PC and push nothing (stall).
REQ-022 SHALL give redirect_valid highest priority: flush the FIFO (count <= 0), PC <= redirect_pc, push nothing and pop nothing that cycle, state <= RUN, and clear fault_pc to 0.
REQ-023 SHALL perform simultaneous push and pop in one cycle, leaving count unchanged and preserving order.
REQ-024 SHALL keep the fetch-to-out_valid latency at 1 cycle: an instruction pushed at edge N is visible after edge N.
REQ-025 SHALL add PC+4 modulo 2^32; the wrap result is caught by REQ-018.
REQ-026 SHALL sustain 1 instruction/cycle while out_ready is held high.
REQ-027 SHALL, in FAULT, leave PC and fault_pc constant until a redirect or reset.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, set PC=RESET_PC, count=0, state=RUN and fault_pc=0, regardless of redirect or handshake inputs.
REQ-029 SHALL hold outputs after reset at out_valid=0, fault=0, fault_pc=0, im_addr=RESET_PC, with out_inst/out_pc don't-care while out_valid=0.
REQ-030 SHALL, on reset asserted mid-stream, discard buffered entries in the same edge.

Structure
REQ-031 SHALL take RESET_PC/IM_WORDS defaults, the RUN/FAULT state encoding and the {pc, inst} entry type from a shared package fetch_pkg.
REQ-032 SHALL place the FIFO in one sub-module fetch_fifo2 (2-entry, push/pop/flush, count output).

Verification
REQ-033 SHALL cover: reset release with out_ready=1 -> out_pc = 0x3000, 0x3004, 0x3008 on consecutive cycles; out_inst = ROM words 0, 1, 2.
REQ-034 SHALL cover: out_ready=0 for 5 cycles after reset -> count saturates at 2 and im_addr holds 0x3008; on ready release -> out_pc = 0x3000, 0x3004, 0x3008 with no gap and no duplicate.
REQ-035 SHALL cover: redirect_valid=1, redirect_pc=0x3040 while 2 entries are buffered -> next cycle out_valid=0; the following cycle out_pc=0x3040.
REQ-036 SHALL cover: redirect to 0x3002 -> next cycle fault=1 and fault_pc=0x3002 with no push; redirect to 0x3000 -> fault=0 and fetch resumes.
REQ-037 SHALL cover: sequential fetch reaching 0x5000 (RESET_PC+8192) -> last delivered out_pc=0x4FFC, then fault=1 with fault_pc=0x5000.
REQ-038 SHALL cover: reset asserted with 2 buffered entries and redirect_valid=1 -> after the edge out_valid=0 and im_addr=0x3000 (reset wins).
